// File: rtl/second_countdown_if.sv
// ----------------------------------------------------------------------------
// second_countdown_if
//
// Bundle between the game FSM and the seconds countdown block.
//   enable       : one-second tick strobe, one CLOCK_50 cycle wide
//   start        : synchronous pulse, load and begin counting
//   hold         : level, freeze the count and drop ticks while high
//   seconds_bcd  : remaining seconds, [7:4] tens, [3:0] units
//   running      : high while counting
//   expired      : one-cycle pulse when the count reaches zero
//   done         : level, high once time has run out
//   warn         : only with SECOND_COUNTDOWN_WARN_EN, last-seconds blink
//
// master: the game FSM side (drives enable/start/hold).
// slave : the countdown block.
// ----------------------------------------------------------------------------
interface second_countdown_if;
    logic       enable;
    logic       start;
    logic       hold;
    logic [7:0] seconds_bcd;
    logic       running;
    logic       expired;
    logic       done;
`ifdef SECOND_COUNTDOWN_WARN_EN
    logic       warn;
`endif

    modport master (
        output enable, start, hold,
        input  seconds_bcd, running, expired, done
`ifdef SECOND_COUNTDOWN_WARN_EN
        , input warn
`endif
    );

    modport slave (
        input  enable, start, hold,
        output seconds_bcd, running, expired, done
`ifdef SECOND_COUNTDOWN_WARN_EN
        , output warn
`endif
    );
endinterface

// File: rtl/second_countdown.sv
// ----------------------------------------------------------------------------
// second_countdown
//
// Counts whole seconds down from LOAD_SECONDS, one step per accepted tick of
// the one-second strobe. Used for the frame/shot time limit and the two-digit
// seven-segment time display.
//
// Parameters:
//   LOAD_SECONDS : reload value in seconds, 0..99
//   DIGITS_BCD   : 1 = count held as two BCD digits,
//                  0 = count held in binary, converted to BCD for display
//
// Ports:
//   CLOCK_50 : 50 MHz system clock
//   KEY      : asynchronous active-low reset
//   bus      : second_countdown_if.slave (enable/start/hold in,
//              seconds_bcd/running/expired/done[/warn] out)
//
// Optional feature (macro SECOND_COUNTDOWN_WARN_EN): adds bus.warn, which
// blinks on each accepted tick once three or fewer seconds remain.
// ----------------------------------------------------------------------------
module second_countdown #(
    parameter int LOAD_SECONDS = 10,
    parameter int DIGITS_BCD   = 1
) (
    input  logic              CLOCK_50,
    input  logic              KEY,
    second_countdown_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Reload value in the register's own encoding. Values 0..3 encode the
    // same in BCD and binary, so the "== 1" / "<= 3" tests below work for both.
    localparam logic [7:0] LOAD_BCD   = {4'(LOAD_SECONDS / 10), 4'(LOAD_SECONDS % 10)};
    localparam logic [7:0] LOAD_VALUE = (DIGITS_BCD != 0) ? LOAD_BCD : 8'(LOAD_SECONDS);
    localparam bit         LOAD_ZERO  = (LOAD_SECONDS == 0);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       expired_q, expired_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
`ifdef SECOND_COUNTDOWN_WARN_EN
    logic       warn_q, warn_d;
`endif

    // One-second decrement; 00 is terminal in both encodings.
    function automatic logic [7:0] dec_count(input logic [7:0] v);
        if (DIGITS_BCD != 0) begin
            if (v[3:0] != 4'd0)
                return {v[7:4], v[3:0] - 4'd1};
            else if (v[7:4] != 4'd0)
                return {v[7:4] - 4'd1, 4'd9};
            else
                return v;
        end else begin
            if (v != 8'd0)
                return v - 8'd1;
            else
                return v;
        end
    endfunction

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
`ifdef SECOND_COUNTDOWN_WARN_EN
        warn_d    = warn_q;
`endif

        if (bus.start) begin
            // Start (or restart) wins over a same-cycle tick in every state.
            count_d = LOAD_VALUE;
`ifdef SECOND_COUNTDOWN_WARN_EN
            warn_d  = 1'b0;
`endif
            if (LOAD_ZERO) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
            end else begin
                state_d   = ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // Ticks under hold are dropped, not queued.
                    if (bus.enable && !bus.hold) begin
                        count_d = dec_count(count_q);
                        if (count_q == 8'd1) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end
`ifdef SECOND_COUNTDOWN_WARN_EN
                        if (count_q == 8'd1)
                            warn_d = 1'b0;
                        else if (count_d == 8'd3)
                            warn_d = 1'b1;
                        else if (count_d < 8'd3)
                            warn_d = ~warn_q;
`endif
                    end
                end
                ST_DONE: begin
`ifdef SECOND_COUNTDOWN_WARN_EN
                    warn_d = 1'b0;
`endif
                end
                default: begin
`ifdef SECOND_COUNTDOWN_WARN_EN
                    warn_d = 1'b0;
`endif
                end
            endcase
        end

        // Status flags are decoded from the next state so they come
        // straight out of flops.
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q   <= ST_IDLE;
            count_q   <= LOAD_VALUE;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SECOND_COUNTDOWN_WARN_EN
            warn_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef SECOND_COUNTDOWN_WARN_EN
            warn_q    <= warn_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        if (DIGITS_BCD != 0) begin : g_bcd
            assign bus.seconds_bcd = count_q;
        end else begin : g_bin
            // Binary count is at most 99, so quotient and remainder each fit a digit.
            assign bus.seconds_bcd = {4'(count_q / 8'd10), 4'(count_q % 8'd10)};
        end
    endgenerate

    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;
`ifdef SECOND_COUNTDOWN_WARN_EN
    assign bus.warn    = warn_q;
`endif

endmodule

// File: tb/tb_second_countdown.sv
// ----------------------------------------------------------------------------
// tb_second_countdown
//
// Drives five countdown instances (different reload values and both register
// encodings) from one shared stimulus stream and compares every output each
// cycle against an integer-seconds reference model, plus directed spot checks.
// ----------------------------------------------------------------------------
module tb_second_countdown;

    localparam int N = 5;
    localparam int LOADS [N] = '{10, 25, 0, 25, 5};
    localparam int BCDS  [N] = '{1,  1,  1, 0,  1};
    localparam logic [7:0] SEQ10 [10] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                                          8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    logic clk = 1'b0;
    logic key = 1'b1;
    logic enable = 1'b0;
    logic start  = 1'b0;
    logic hold   = 1'b0;

    logic [7:0] bcd_o  [N];
    logic       run_o  [N];
    logic       exp_o  [N];
    logic       done_o [N];
`ifdef SECOND_COUNTDOWN_WARN_EN
    logic       warn_o [N];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        second_countdown_if sc_if ();
        assign sc_if.enable = enable;
        assign sc_if.start  = start;
        assign sc_if.hold   = hold;

        second_countdown #(
            .LOAD_SECONDS (LOADS[g]),
            .DIGITS_BCD   (BCDS[g])
        ) u_dut (
            .CLOCK_50 (clk),
            .KEY      (key),
            .bus      (sc_if)
        );

        assign bcd_o[g]  = sc_if.seconds_bcd;
        assign run_o[g]  = sc_if.running;
        assign exp_o[g]  = sc_if.expired;
        assign done_o[g] = sc_if.done;
`ifdef SECOND_COUNTDOWN_WARN_EN
        assign warn_o[g] = sc_if.warn;
`endif
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: remaining seconds as an integer plus running/done flags.
    int m_rem  [N];
    bit m_run  [N];
    bit m_done [N];
    bit m_exp  [N];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_rem[i]  = LOADS[i];
            m_run[i]  = 1'b0;
            m_done[i] = 1'b0;
            m_exp[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic en, input logic st, input logic hd);
        for (int i = 0; i < N; i++) begin
            m_exp[i] = 1'b0;
            if (st) begin
                m_rem[i] = LOADS[i];
                if (LOADS[i] == 0) begin
                    m_run[i] = 1'b0; m_done[i] = 1'b1; m_exp[i] = 1'b1;
                end else begin
                    m_run[i] = 1'b1; m_done[i] = 1'b0;
                end
            end else if (m_run[i] && en && !hd) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_run[i] = 1'b0; m_done[i] = 1'b1; m_exp[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < N; i++) begin
            check($sformatf("bcd[%0d]", i), bcd_o[i],
                  {4'(m_rem[i] / 10), 4'(m_rem[i] % 10)});
            check($sformatf("running[%0d]", i), 8'(run_o[i]), 8'(m_run[i]));
            check($sformatf("expired[%0d]", i), 8'(exp_o[i]), 8'(m_exp[i]));
            check($sformatf("done[%0d]", i), 8'(done_o[i]), 8'(m_done[i]));
`ifdef SECOND_COUNTDOWN_WARN_EN
            // Blink pattern: 1 at 3 s, 0 at 2 s, 1 at 1 s, off otherwise.
            check($sformatf("warn[%0d]", i), 8'(warn_o[i]),
                  8'(m_run[i] && m_rem[i] <= 3 && ((3 - m_rem[i]) % 2 == 0)));
`endif
        end
    endtask

    // One clock: drive inputs just after an edge, advance, check just after.
    task automatic cycle(input logic en, input logic st, input logic hd);
        enable = en;
        start  = st;
        hold   = hd;
        @(posedge clk);
        model_step(en, st, hd);
        #1;
        check_model();
    endtask

    task automatic idle(input int n, input logic hd);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, hd);
    endtask

    initial begin
        bit prev_en;
        logic en, st, hd;

        // Reset state (force a real falling edge on KEY).
        model_reset();
        #1 key = 1'b0;
        #1;
        check("reset_bcd10", bcd_o[0], 8'h10);
        check("reset_bcd25", bcd_o[1], 8'h25);
        check("reset_running", 8'(run_o[0]), 8'h00);
        check("reset_done", 8'(done_o[0]), 8'h00);
        check_model();
        @(posedge clk);
        #1 key = 1'b1;

        // Ticks in IDLE are ignored.
        cycle(1'b1, 1'b0, 1'b0);
        check("idle_tick", bcd_o[0], 8'h10);
        idle(3, 1'b0);

        // Start: LOAD=0 instance finishes at once.
        cycle(1'b0, 1'b1, 1'b0);
        check("start_bcd10", bcd_o[0], 8'h10);
        check("start_running10", 8'(run_o[0]), 8'h01);
        check("load0_done", 8'(done_o[2]), 8'h01);
        check("load0_expired", 8'(exp_o[2]), 8'h01);
        check("load0_bcd", bcd_o[2], 8'h00);
        cycle(1'b0, 1'b0, 1'b0);
        check("load0_expired_width", 8'(exp_o[2]), 8'h00);
        idle(18, 1'b0);

        // Ten ticks spaced 20 cycles apart on the LOAD=10 instance.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check($sformatf("seq10_%0d", k), bcd_o[0], SEQ10[k]);
`ifdef SECOND_COUNTDOWN_WARN_EN
            if (k == 1) check("warn5_at3", 8'(warn_o[4]), 8'h01);
            if (k == 2) check("warn5_at2", 8'(warn_o[4]), 8'h00);
            if (k == 3) check("warn5_at1", 8'(warn_o[4]), 8'h01);
            if (k == 4) check("warn5_done", 8'(warn_o[4]), 8'h00);
`endif
            if (k == 9) begin
                check("expired10_hi", 8'(exp_o[0]), 8'h01);
                check("done10", 8'(done_o[0]), 8'h01);
                check("running10_lo", 8'(run_o[0]), 8'h00);
            end
            cycle(1'b0, 1'b0, 1'b0);
            if (k == 9) begin
                check("expired10_lo", 8'(exp_o[0]), 8'h00);
                check("done10_hold", 8'(done_o[0]), 8'h01);
            end
            idle(18, 1'b0);
        end

        // Ticks in DONE are ignored.
        cycle(1'b1, 1'b0, 1'b0);
        check("done_tick", bcd_o[0], 8'h00);
        idle(5, 1'b0);

        // Units borrow 20 -> 19 on the LOAD=25 instances.
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            idle(19, 1'b0);
        end
        check("borrow25_bcd", bcd_o[1], 8'h19);
        check("borrow25_bin", bcd_o[3], 8'h19);

        // Hold: four ticks dropped, then one accepted.
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            idle(19, 1'b0);
        end
        check("pre_hold", bcd_o[0], 8'h07);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b1);
            check($sformatf("held_%0d", k), bcd_o[0], 8'h07);
            idle(19, 1'b1);
        end
        idle(2, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("post_hold", bcd_o[0], 8'h06);
        idle(19, 1'b0);

        // Start and tick together at 0x04: reload wins.
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            idle(19, 1'b0);
        end
        check("pre_restart", bcd_o[0], 8'h04);
        cycle(1'b1, 1'b1, 1'b0);
        check("restart_bcd", bcd_o[0], 8'h10);
        check("restart_running", 8'(run_o[0]), 8'h01);
        idle(19, 1'b0);

        // Asynchronous reset mid-count at 0x05.
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            idle(19, 1'b0);
        end
        check("pre_reset", bcd_o[0], 8'h05);
        #2 key = 1'b0;
        #1;
        check("async_bcd", bcd_o[0], 8'h10);
        check("async_running", 8'(run_o[0]), 8'h00);
        check("async_done", 8'(done_o[0]), 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        key = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        check("reset_idle_tick", bcd_o[0], 8'h10);
        check("reset_idle_run", 8'(run_o[0]), 8'h00);
        idle(5, 1'b0);

        // Randomized traffic against the model.
        prev_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            en = !prev_en && ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 79) == 0);
            hd = ($urandom_range(0, 6) == 0);
            prev_en = en;
            cycle(en, st, hd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/second_countdown.md
Name: second_countdown

Overview:
- Consumer end of the one-second tick interface: takes the single-cycle `enable` strobe from the one-second tick generator and counts whole seconds down from a loaded value.
- Drives the frame/shot time limit in the main game FSM and the two-digit seven-segment time display.
- Reports a one-cycle `expired` pulse and a `done` level when time runs out.
- Supports a hold (pause) input for the ball-roll animation.

Parameters:
- LOAD_SECONDS, 10, initial countdown value in seconds; legal range 0..99.
- DIGITS_BCD, 1, 1 = the seconds register is stored and decremented as two BCD digits; 0 = stored as 7-bit binary, and `seconds_bcd` is produced by a combinational binary-to-BCD conversion.

Ports:
- CLOCK_50, input, 1, system clock, 50 MHz.
- KEY, input, 1, asynchronous active-low reset.
- enable, input, 1, one-second tick strobe, high for exactly one CLOCK_50 cycle.
- start, input, 1, synchronous pulse; load LOAD_SECONDS and begin counting.
- hold, input, 1, level; while high, ticks are ignored and the count freezes.
- seconds_bcd, output, 8, remaining seconds; [7:4] = tens, [3:0] = units.
- running, output, 1, high in RUN state.
- expired, output, 1, one-cycle pulse on reaching zero.
- done, output, 1, level, high in DONE state.

Behaviour:
- Reset (KEY=0, asynchronous):
  - state = IDLE, seconds = LOAD_SECONDS, running = 0, expired = 0, done = 0.
  - Reset takes effect immediately, including mid-count.
- States and transitions:
  - IDLE: start=1 loads LOAD_SECONDS. If LOAD_SECONDS=0, go to DONE and pulse expired. Otherwise go to RUN.
  - RUN: start=1 reloads LOAD_SECONDS and stays in RUN (restart); start has priority over a same-cycle tick.
  - RUN, enable=1 and hold=0: decrement seconds by 1. If the pre-decrement value is 1, go to DONE with expired=1 in that same registered cycle.
  - RUN, hold=1: seconds frozen; every tick arriving while held is dropped, not queued.
  - DONE: seconds stay at 00; done=1. start=1 reloads and goes to RUN (or stays in DONE with an expired pulse if LOAD_SECONDS=0). Ticks are ignored.
- Latency:
  - seconds_bcd updates on the clock edge that samples enable=1, so it is visible one cycle after the strobe.
  - expired asserts in the same cycle as seconds_bcd first reads 00.
  - expired is exactly one cycle wide.
- BCD decrement rules:
  - units > 0: units−1.
  - units = 0 and tens > 0: units=9, tens−1.
  - No wrap below 00; 00 is terminal.
- The seconds register is never written outside the state rules above; hold has no effect in IDLE or DONE.
- running = (state==RUN); done = (state==DONE). Both are registered and glitch-free.
- The block performs no synchronisation of start/hold; the game FSM drives them from CLOCK_50.

Optional Feature:
- Macro: SECOND_COUNTDOWN_WARN_EN.
- When defined:
  - Adds output `warn` (1 bit).
  - In RUN with seconds ≤ 3, warn toggles on every accepted tick, starting at 1 on the tick that reaches 3.
  - warn is forced to 0 in IDLE, DONE, on reset, and on restart.
  - While hold=1, warn holds its value.
- When not defined: no `warn` port and no associated logic.

Test Plan:
- Reset then start, LOAD_SECONDS=10, 10 ticks spaced 20 cycles apart:
  - seconds_bcd steps 0x10, 0x09 … 0x01, 0x00.
  - expired is high for one cycle exactly when 0x00 appears; done=1 and running=0 afterwards.
- LOAD_SECONDS=25, start, 6 ticks -> seconds_bcd=0x19, which checks the units borrow from 20 to 19.
- Hold asserted after 3 ticks (0x07) while 4 ticks arrive, then released, then 1 tick -> reads 0x07 throughout the hold and 0x06 after the release tick.
- Start and enable in the same cycle while RUN at 0x04 -> reloads to 0x10; that tick is not applied.
- KEY pulled low mid-count at 0x05 -> outputs go immediately to 0x10, running=0, done=0, and return to IDLE. A tick with no start leaves the count at 0x10.
- LOAD_SECONDS=0, start -> next cycle done=1, expired pulses once, seconds_bcd=0x00. Under SECOND_COUNTDOWN_WARN_EN with LOAD_SECONDS=5, warn is 1 at 0x03, 0 at 0x02, 1 at 0x01, and 0 in DONE.
